// File: rtl/banked_tile_cache_if.sv
// Request/response bundle for the two banked_tile_cache requesters (CISA and DMA).
// master = requester side, slave = cache side.
interface banked_tile_cache_if #(
    parameter int TILE_WIDTH = 288,
    parameter int AW         = 5
);
    logic                  cisa_req_valid;
    logic                  cisa_req_we;
    logic [AW-1:0]         cisa_req_addr;
    logic [TILE_WIDTH-1:0] cisa_req_wdat;
    logic                  cisa_req_ready;
    logic                  cisa_rsp_valid;
    logic [TILE_WIDTH-1:0] cisa_rsp_dat;

    logic                  dma_req_valid;
    logic                  dma_req_we;
    logic [AW-1:0]         dma_req_addr;
    logic [TILE_WIDTH-1:0] dma_req_wdat;
    logic                  dma_req_ready;
    logic                  dma_rsp_valid;
    logic [TILE_WIDTH-1:0] dma_rsp_dat;

    modport master (
        output cisa_req_valid, cisa_req_we, cisa_req_addr, cisa_req_wdat,
        input  cisa_req_ready, cisa_rsp_valid, cisa_rsp_dat,
        output dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdat,
        input  dma_req_ready, dma_rsp_valid, dma_rsp_dat
    );

    modport slave (
        input  cisa_req_valid, cisa_req_we, cisa_req_addr, cisa_req_wdat,
        output cisa_req_ready, cisa_rsp_valid, cisa_rsp_dat,
        input  dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdat,
        output dma_req_ready, dma_rsp_valid, dma_rsp_dat
    );
endinterface

// File: rtl/banked_tile_cache.sv
// Banked tile scratchpad shared by CISA (priority) and DMA (anti-starvation window).
// Optional BANKED_TILE_CACHE_STATS_EN adds a saturating conflict_count output.
module banked_tile_cache #(
    parameter int TILE_WIDTH   = 288,
    parameter int DEPTH        = 32,
    parameter int BANKS        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  freeze,
    banked_tile_cache_if.slave    bus,
    output logic                  starved
`ifdef BANKED_TILE_CACHE_STATS_EN
    ,
    output logic [31:0]           conflict_count
`endif
);
    localparam int AW   = $clog2(DEPTH);
    localparam int BW   = $clog2(BANKS);
    localparam int ROWS = DEPTH / BANKS;
    localparam int BW_I = (BW > 0) ? BW : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {NORMAL, DMA_PRIO} state_t;

    function automatic logic [BW_I-1:0] bank_of(input logic [AW-1:0] a);
        return (BANKS == 1) ? '0 : BW_I'(a);
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
        return RW'(a >> BW);
    endfunction

    state_t                state;
    logic [7:0]            starve_cnt;
    logic [BW_I-1:0]       cisa_bank, dma_bank;
    logic [RW-1:0]         cisa_row, dma_row;
    logic                  conflict, active;
    logic                  cisa_ready, dma_ready;
    logic                  cisa_go, dma_go;
    logic                  cisa_rsp_valid, dma_rsp_valid;
    logic [TILE_WIDTH-1:0] cisa_rsp_dat, dma_rsp_dat;
    logic [TILE_WIDTH-1:0] bank_rdata [BANKS];

    assign cisa_bank = bank_of(bus.cisa_req_addr);
    assign dma_bank  = bank_of(bus.dma_req_addr);
    assign cisa_row  = row_of(bus.cisa_req_addr);
    assign dma_row   = row_of(bus.dma_req_addr);
    assign conflict  = bus.cisa_req_valid && bus.dma_req_valid && (cisa_bank == dma_bank);
    assign active    = !freeze && !reset;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        cisa_ready = 1'b0;
        dma_ready  = 1'b0;
        if (active) begin
            cisa_ready = (state == NORMAL)   || !conflict;
            dma_ready  = (state == DMA_PRIO) || !conflict;
        end
    end

    assign cisa_go = bus.cisa_req_valid && cisa_ready;
    assign dma_go  = bus.dma_req_valid && dma_ready;

    // Each bank sees at most one granted requester, so one address port per bank suffices.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [TILE_WIDTH-1:0] mem [ROWS];
        logic                  cisa_sel, dma_sel, wr;
        logic [RW-1:0]         row;
        logic [TILE_WIDTH-1:0] wdat;

        assign cisa_sel = cisa_go && (cisa_bank == BW_I'(b));
        assign dma_sel  = dma_go && (dma_bank == BW_I'(b));
        assign row      = cisa_sel ? cisa_row : dma_row;
        assign wr       = (cisa_sel && bus.cisa_req_we) || (dma_sel && bus.dma_req_we);
        assign wdat     = cisa_sel ? bus.cisa_req_wdat : bus.dma_req_wdat;

        // NOTE: storage arrays have no reset; contents stay undefined until written.
        always_ff @(posedge clk) begin
            if (wr) mem[row] <= wdat;
        end

        assign bank_rdata[b] = mem[row];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cisa_rsp_valid <= 1'b0;
            dma_rsp_valid  <= 1'b0;
            cisa_rsp_dat   <= '0;
            dma_rsp_dat    <= '0;
        end else if (!freeze) begin
            cisa_rsp_valid <= cisa_go && !bus.cisa_req_we;
            dma_rsp_valid  <= dma_go && !bus.dma_req_we;
            if (cisa_go && !bus.cisa_req_we) cisa_rsp_dat <= bank_rdata[cisa_bank];
            if (dma_go && !bus.dma_req_we)   dma_rsp_dat  <= bank_rdata[dma_bank];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else if (!freeze) begin
            case (state)
                NORMAL: begin
                    if (bus.dma_req_valid && !dma_ready) begin
                        if (starve_cnt == 8'(STARVE_LIMIT - 1)) begin
                            state      <= DMA_PRIO;
                            starve_cnt <= '0;
                        end else begin
                            starve_cnt <= starve_cnt + 8'd1;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                DMA_PRIO: begin
                    if (!bus.dma_req_valid || dma_go) state <= NORMAL;
                end
                default: state <= NORMAL;
            endcase
        end
    end

`ifdef BANKED_TILE_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_count <= '0;
        end else if (!freeze && conflict && (conflict_count != '1)) begin
            conflict_count <= conflict_count + 32'd1;
        end
    end
`endif

    assign starved            = (state == DMA_PRIO);
    assign bus.cisa_req_ready = cisa_ready;
    assign bus.dma_req_ready  = dma_ready;
    assign bus.cisa_rsp_valid = cisa_rsp_valid;
    assign bus.dma_rsp_valid  = dma_rsp_valid;
    assign bus.cisa_rsp_dat   = cisa_rsp_dat;
    assign bus.dma_rsp_dat    = dma_rsp_dat;
endmodule

// File: tb/tb_banked_tile_cache.sv
// Self-checking bench for banked_tile_cache: address-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_banked_tile_cache;
    localparam int TW    = 288;
    localparam int DEPTH = 32;
    localparam int BANKS = 4;
    localparam int LIMIT = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [TW-1:0] P2A = {16{18'h0002A}};
    localparam logic [TW-1:0] PX  = {16{18'h15555}};

    logic clk;
    logic reset;
    logic freeze;
    logic starved;
`ifdef BANKED_TILE_CACHE_STATS_EN
    logic [31:0] conflict_count;
`endif

    banked_tile_cache_if #(.TILE_WIDTH(TW), .AW(AW)) bus ();

    banked_tile_cache #(
        .TILE_WIDTH(TW), .DEPTH(DEPTH), .BANKS(BANKS), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .freeze(freeze),
        .bus(bus),
        .starved(starved)
`ifdef BANKED_TILE_CACHE_STATS_EN
        ,
        .conflict_count(conflict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] pat(input int a);
        logic [17:0] lane;
        lane = 18'(a * 3 + 1);
        return {16{lane}};
    endfunction

    // Reference model: flat address-indexed memory, a priority flag and a denial count.
    logic [TW-1:0] m_mem [DEPTH];
    bit            m_prio;
    int            m_cnt;
    bit            m_crv, m_drv;
    logic [TW-1:0] m_crd, m_drd;
    longint        m_conf;
    bit            m_started = 1'b0;

    function automatic bit m_conflict();
        return bus.cisa_req_valid && bus.dma_req_valid &&
               ((int'(bus.cisa_req_addr) % BANKS) == (int'(bus.dma_req_addr) % BANKS));
    endfunction

    function automatic bit m_cready();
        return !freeze && !reset && (!m_prio || !m_conflict());
    endfunction

    function automatic bit m_dready();
        return !freeze && !reset && (m_prio || !m_conflict());
    endfunction

    always @(posedge clk) begin
        bit cg, dg, conf;
        if (reset) begin
            m_prio    = 1'b0;
            m_cnt     = 0;
            m_crv     = 1'b0;
            m_drv     = 1'b0;
            m_crd     = '0;
            m_drd     = '0;
            m_conf    = 0;
            m_started = 1'b1;
        end else if (!freeze) begin
            cg   = bus.cisa_req_valid && m_cready();
            dg   = bus.dma_req_valid && m_dready();
            conf = m_conflict();
            m_crv = cg && !bus.cisa_req_we;
            m_drv = dg && !bus.dma_req_we;
            if (m_crv) m_crd = m_mem[bus.cisa_req_addr];
            if (m_drv) m_drd = m_mem[bus.dma_req_addr];
            if (cg && bus.cisa_req_we) m_mem[bus.cisa_req_addr] = bus.cisa_req_wdat;
            if (dg && bus.dma_req_we)  m_mem[bus.dma_req_addr]  = bus.dma_req_wdat;
            if (!m_prio) begin
                if (bus.dma_req_valid && !dg) begin
                    m_cnt++;
                    if (m_cnt >= LIMIT) begin
                        m_prio = 1'b1;
                        m_cnt  = 0;
                    end
                end else begin
                    m_cnt = 0;
                end
            end else if (!bus.dma_req_valid || dg) begin
                m_prio = 1'b0;
            end
            if (conf && m_conf < 64'hFFFF_FFFF) m_conf++;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("cisa_req_ready", TW'(bus.cisa_req_ready), TW'(m_cready()));
            check("dma_req_ready",  TW'(bus.dma_req_ready),  TW'(m_dready()));
            check("starved",        TW'(starved),            TW'(m_prio));
            check("cisa_rsp_valid", TW'(bus.cisa_rsp_valid), TW'(m_crv));
            check("dma_rsp_valid",  TW'(bus.dma_rsp_valid),  TW'(m_drv));
            check("cisa_rsp_dat",   bus.cisa_rsp_dat,        m_crd);
            check("dma_rsp_dat",    bus.dma_rsp_dat,         m_drd);
`ifdef BANKED_TILE_CACHE_STATS_EN
            check("conflict_count", TW'(conflict_count),     TW'(m_conf));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c(input bit v, input bit we, input int a, input logic [TW-1:0] d);
        bus.cisa_req_valid = v;
        bus.cisa_req_we    = we;
        bus.cisa_req_addr  = AW'(a);
        bus.cisa_req_wdat  = d;
    endtask

    task automatic drive_d(input bit v, input bit we, input int a, input logic [TW-1:0] d);
        bus.dma_req_valid = v;
        bus.dma_req_we    = we;
        bus.dma_req_addr  = AW'(a);
        bus.dma_req_wdat  = d;
    endtask

    task automatic idle();
        drive_c(1'b0, 1'b0, 0, '0);
        drive_d(1'b0, 1'b0, 0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ci, di;
        bit cv, cg, dg;

        reset  = 1'b1;
        freeze = 1'b0;
        idle();
        drive_c(1'b1, 1'b0, 3, '0);
        cyc();
        cyc();
        #1;
        check("reset_cisa_ready", TW'(bus.cisa_req_ready), '0);
        check("reset_starved",    TW'(starved),            '0);
        check("reset_rsp_valid",  TW'(bus.cisa_rsp_valid), '0);
        check("reset_rsp_dat",    bus.cisa_rsp_dat,        '0);
        check("reset_dma_dat",    bus.dma_rsp_dat,         '0);

        reset = 1'b0;
        idle();
        cyc();

        // Fill every address: CISA even, DMA odd, always in different banks.
        for (int a = 0; a < DEPTH; a += 2) begin
            drive_c(1'b1, 1'b1, a, pat(a));
            drive_d(1'b1, 1'b1, a + 1, pat(a + 1));
            cyc();
        end

        // Store then load the same address on back-to-back cycles.
        drive_c(1'b1, 1'b1, 5, P2A);
        drive_d(1'b0, 1'b0, 0, '0);
        cyc();
        drive_c(1'b1, 1'b0, 5, '0);
        cyc();
        idle();
        #1;
        check("st_ld_valid", TW'(bus.cisa_rsp_valid), TW'(1));
        check("st_ld_dat",   bus.cisa_rsp_dat,        P2A);

        // Parallel loads in banks 1 and 2.
        drive_c(1'b1, 1'b0, 1, '0);
        drive_d(1'b1, 1'b0, 2, '0);
        #1;
        check("par_cisa_ready", TW'(bus.cisa_req_ready), TW'(1));
        check("par_dma_ready",  TW'(bus.dma_req_ready),  TW'(1));
        cyc();
        idle();
        #1;
        check("par_cisa_dat", bus.cisa_rsp_dat, pat(1));
        check("par_dma_dat",  bus.dma_rsp_dat,  pat(2));
        check("par_dma_valid", TW'(bus.dma_rsp_valid), TW'(1));

        // Bank-0 conflict: CISA wins, DMA store lands once CISA drops.
        drive_c(1'b1, 1'b0, 4, '0);
        drive_d(1'b1, 1'b1, 8, PX);
        #1;
        check("conf_cisa_ready", TW'(bus.cisa_req_ready), TW'(1));
        check("conf_dma_ready",  TW'(bus.dma_req_ready),  TW'(0));
        cyc();
        drive_c(1'b0, 1'b0, 0, '0);
        #1;
        check("conf_dma_retry", TW'(bus.dma_req_ready), TW'(1));
        check("conf_cisa_dat",  bus.cisa_rsp_dat,       pat(4));
        cyc();
        drive_d(1'b1, 1'b0, 8, '0);
        cyc();
        idle();
        #1;
        check("conf_dma_store_dat", bus.dma_rsp_dat, PX);

        // Starvation: continuous CISA bank-0 traffic versus DMA load of addr 0.
        for (int k = 1; k <= 6; k++) begin
            drive_c(1'b1, 1'b0, (k % 4) * 4, '0);
            if (k <= 5) drive_d(1'b1, 1'b0, 0, '0);
            else        drive_d(1'b0, 1'b0, 0, '0);
            #1;
            if (k <= 4) begin
                check("starve_denied", TW'(bus.dma_req_ready), TW'(0));
                check("starve_not_yet", TW'(starved), TW'(0));
            end else if (k == 5) begin
                check("starve_flag",       TW'(starved),            TW'(1));
                check("starve_dma_ready",  TW'(bus.dma_req_ready),  TW'(1));
                check("starve_cisa_ready", TW'(bus.cisa_req_ready), TW'(0));
            end else begin
                check("starve_cleared", TW'(starved),           TW'(0));
                check("starve_dma_dat", bus.dma_rsp_dat,        pat(0));
            end
            cyc();
        end

        // Freeze: counter and pending response hold across three frozen cycles.
        drive_c(1'b1, 1'b0, 4, '0);
        drive_d(1'b1, 1'b0, 8, '0);
        cyc();
        cyc();
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("frz_cisa_ready", TW'(bus.cisa_req_ready), TW'(0));
            check("frz_dma_ready",  TW'(bus.dma_req_ready),  TW'(0));
            check("frz_rsp_valid",  TW'(bus.cisa_rsp_valid), TW'(1));
            check("frz_rsp_dat",    bus.cisa_rsp_dat,        pat(4));
            cyc();
        end
        freeze = 1'b0;
        #1;
        check("unfrz_rsp_held", TW'(bus.cisa_rsp_valid), TW'(1));
        check("unfrz_starved",  TW'(starved),            TW'(0));
        cyc();
        cyc();
        #1;
        check("unfrz_starved_after_cnt", TW'(starved), TW'(1));
        cyc();
        idle();
        #1;
        check("unfrz_prio_released", TW'(starved), TW'(0));

        // Reset (with freeze also high) on the cycle after a load grant.
        drive_c(1'b1, 1'b0, 5, '0);
        cyc();
        idle();
        reset  = 1'b1;
        freeze = 1'b1;
        #1;
        check("rst_pre_valid", TW'(bus.cisa_rsp_valid), TW'(1));
        cyc();
        #1;
        check("rst_rsp_valid", TW'(bus.cisa_rsp_valid), TW'(0));
        check("rst_rsp_dat",   bus.cisa_rsp_dat,        '0);
`ifdef BANKED_TILE_CACHE_STATS_EN
        check("rst_conflict_count", TW'(conflict_count), '0);
`endif
        reset  = 1'b0;
        freeze = 1'b0;
        cyc();

        // Mixed traffic obeying the handshake; the model checks every cycle.
        ci = 0;
        di = 0;
        for (int n = 0; n < 40; n++) begin
            cv = (n % 5) != 4;
            freeze = (n == 17) || (n == 18);
            drive_c(cv, (ci % 3) == 0, (ci * 7 + 1) % DEPTH, pat(ci + 40));
            drive_d(1'b1, (di % 4) == 1, (di * 5 + 2) % DEPTH, pat(di + 80));
            #1;
            cg = cv && bus.cisa_req_ready;
            dg = bus.dma_req_ready;
            cyc();
            if (cg) ci++;
            if (dg) di++;
        end
        freeze = 1'b0;
        idle();
        cyc();
        cyc();
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
